// File: rtl/us_burst_receiver_pkg.sv
// Shared types and constants for the ultrasonic burst receiver.
// State codes, register map and the queued event record.
package us_burst_receiver_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_QUALIFY  = 3'd1;
  localparam logic [2:0] ST_IN_BURST = 3'd2;
  localparam logic [2:0] ST_GAP      = 3'd3;
  localparam logic [2:0] ST_BLANK    = 3'd4;

  localparam logic [15:0] REG_HEAD_TS  = 16'h0000;
  localparam logic [15:0] REG_HEAD_LEN = 16'h0001;
  localparam logic [15:0] REG_STATUS   = 16'h0002;
  localparam logic [15:0] REG_TIME     = 16'h0003;

  localparam logic [31:0] EMPTY_PATTERN = 32'hDEADBEEF;

  typedef struct packed {
    logic [31:0] start_ts;
    logic [31:0] length;
  } evt_t;

endpackage

// File: rtl/us_event_fifo.sv
// Small synchronous event queue with count/full/empty.
// Simultaneous push and pop are both honoured, even when full.
module us_event_fifo
  import us_burst_receiver_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  evt_t                     din,
  output evt_t                     dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  evt_t           mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/us_burst_receiver.sv
// Piezo burst detector: sync, glitch reject, echo blanking,
// timestamped event queue read over Avalon-MM.
module us_burst_receiver
  import us_burst_receiver_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int MIN_PULSE    = 16,
  parameter int GAP_CYCLES   = 2000,
  parameter int BLANK_CYCLES = 7000,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        piezo_interface_in,
  input  logic        tx_active,
  input  logic [15:0] avalon_slave_address,
  input  logic        avalon_slave_write,
  input  logic [31:0] avalon_slave_writedata,
  input  logic        avalon_slave_read,
  output logic [31:0] avalon_slave_readdata,
  output logic        avalon_slave_waitrequest,
  output logic        burst_valid,
  output logic [31:0] burst_timestamp
);

  localparam int HW = $clog2(MIN_PULSE + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int BW = $clog2(BLANK_CYCLES + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_in;
  logic [2:0]             state;
  logic [HW-1:0]          hi_cnt;
  logic [GW-1:0]          gap_cnt;
  logic [BW-1:0]          blank_cnt;
  logic [31:0]            time_cnt;
  logic [31:0]            ts_now;
  logic [31:0]            start_ts;
  logic [31:0]            last_hi;
  logic [7:0]             glitch_cnt;
  logic                   overrun;
  logic                   enable;
  logic                   wait_flag;
  logic [15:0]            reg_sel;
  logic                   wr_en;
  logic                   push;
  logic                   pop;
  evt_t                   new_evt;
  evt_t                   head;
  logic [CW-1:0]          count;
  logic                   full;
  logic                   empty;
  logic [31:0]            rd_mux;

  assign s_in    = sync_q[SYNC_STAGES-1];
  assign ts_now  = time_cnt - 32'(SYNC_STAGES);
  assign reg_sel = avalon_slave_address >> 8;

  assign avalon_slave_waitrequest = avalon_slave_read && wait_flag;
  assign wr_en = avalon_slave_write && !avalon_slave_waitrequest;
  assign pop   = wr_en && (reg_sel == REG_HEAD_TS);

  assign push = (state == ST_GAP) && !s_in && !tx_active && enable
             && (gap_cnt == GW'(GAP_CYCLES - 1));

  assign new_evt = '{start_ts: start_ts,
                     length:   last_hi - start_ts + 32'd1};

  us_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (new_evt),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q   <= '0;
      time_cnt <= '0;
      enable   <= 1'b1;
      overrun  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], piezo_interface_in};
      if (wr_en && reg_sel == REG_TIME)
        time_cnt <= avalon_slave_writedata;
      else
        time_cnt <= time_cnt + 32'd1;
      if (wr_en && reg_sel == REG_STATUS)
        enable <= (avalon_slave_writedata != '0);
      if (push && full && !pop)
        overrun <= 1'b1;
      else if (wr_en && reg_sel == REG_HEAD_LEN)
        overrun <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      hi_cnt     <= '0;
      gap_cnt    <= '0;
      blank_cnt  <= '0;
      start_ts   <= '0;
      last_hi    <= '0;
      glitch_cnt <= '0;
    end else begin
      if (tx_active) begin
        state     <= ST_BLANK;
        blank_cnt <= '0;
      end else if (!enable && state != ST_BLANK) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: if (s_in) begin
            state    <= ST_QUALIFY;
            start_ts <= ts_now;
            last_hi  <= ts_now;
            hi_cnt   <= HW'(1);
          end
          ST_QUALIFY: if (s_in) begin
            hi_cnt  <= hi_cnt + 1'b1;
            last_hi <= ts_now;
            if (hi_cnt == HW'(MIN_PULSE - 1)) state <= ST_IN_BURST;
          end else begin
            state <= ST_IDLE;
            if (glitch_cnt != 8'hFF) glitch_cnt <= glitch_cnt + 8'd1;
          end
          ST_IN_BURST: if (s_in) begin
            last_hi <= ts_now;
          end else begin
            state   <= ST_GAP;
            gap_cnt <= GW'(1);
          end
          ST_GAP: if (s_in) begin
            state   <= ST_IN_BURST;
            last_hi <= ts_now;
          end else if (push) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
          ST_BLANK: if (blank_cnt == BW'(BLANK_CYCLES - 1))
            state <= ST_IDLE;
          else
            blank_cnt <= blank_cnt + 1'b1;
          default: state <= ST_IDLE;
        endcase
      end
      if (wr_en && reg_sel == REG_HEAD_LEN) glitch_cnt <= '0;
    end
  end

  always_comb begin
    rd_mux = EMPTY_PATTERN;
    unique case (1'b1)
      (reg_sel == REG_HEAD_TS):
        rd_mux = empty ? EMPTY_PATTERN : head.start_ts;
      (reg_sel == REG_HEAD_LEN):
        rd_mux = empty ? EMPTY_PATTERN : head.length;
      (reg_sel == REG_STATUS):
        rd_mux = {15'd0, overrun, glitch_cnt, 8'(count)};
      (reg_sel == REG_TIME):
        rd_mux = time_cnt;
      default: ;
    endcase
  end

  // One wait state per read: capture on the stalled cycle, release next.
  always_ff @(posedge clock) begin
    if (reset) begin
      avalon_slave_readdata <= '0;
      wait_flag             <= 1'b1;
      burst_valid           <= 1'b0;
      burst_timestamp       <= '0;
    end else begin
      if (avalon_slave_read && wait_flag) begin
        avalon_slave_readdata <= rd_mux;
        wait_flag             <= 1'b0;
      end else begin
        wait_flag <= 1'b1;
      end
      burst_valid <= push;
      if (push) burst_timestamp <= start_ts;
    end
  end

endmodule
